// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of JK cells: derives per-bit j/k excitation
// from the latched op and a registered mirror q of the bank contents.
// state | meaning: IDLE accept command | EXEC drive j/k, step q | DONE one-cycle completion pulse
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_RESET  = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DOWN   = 3'd6;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_data;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_remaining;
    logic [WIDTH-1:0]   w_j;
    logic [WIDTH-1:0]   w_k;
    logic [WIDTH-1:0]   w_up;
    logic [WIDTH-1:0]   w_dn;
    logic               w_accept;
    logic               w_multi;

    // Ripple terms: bit i flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        w_up    = '0;
        w_dn    = '0;
        w_up[0] = 1'b1;
        w_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_up[i] = w_up[i-1] & r_q[i-1];
            w_dn[i] = w_dn[i-1] & ~r_q[i-1];
        end
    end

    assign w_multi = (r_op == OP_TOGGLE) || (r_op == OP_UP) || (r_op == OP_DOWN);

    always_comb begin
        w_next   = r_state;
        w_j      = '0;
        w_k      = '0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    case (cmd_op)
                        OP_LOAD, OP_SET, OP_RESET:  w_next = S_EXEC;
                        OP_TOGGLE, OP_UP, OP_DOWN:  w_next = (cmd_count != '0) ? S_EXEC : S_DONE;
                        default:                    w_next = S_DONE;
                    endcase
                end
            end
            S_EXEC: begin
                w_next = S_DONE;
                if (!abort) begin
                    case (r_op)
                        OP_LOAD:   begin w_j = r_data; w_k = ~r_data; end
                        OP_SET:    begin w_j = '1;     w_k = '0;      end
                        OP_RESET:  begin w_j = '0;     w_k = '1;      end
                        OP_TOGGLE: begin w_j = r_data; w_k = r_data;  end
                        OP_UP:     begin w_j = w_up;   w_k = w_up;    end
                        OP_DOWN:   begin w_j = w_dn;   w_k = w_dn;    end
                        default:   begin w_j = '0;     w_k = '0;      end
                    endcase
                    if (w_multi && (r_remaining != CNT_W'(1)))
                        w_next = S_EXEC;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_data      <= '0;
            r_op        <= '0;
            r_remaining <= '0;
        end else begin
            r_state <= w_next;
            // j=k=0 outside EXEC, so the characteristic equation holds q there.
            r_q     <= (w_j & ~r_q) | (~w_k & r_q);
            if (w_accept) begin
                r_op        <= cmd_op;
                r_data      <= cmd_data;
                r_remaining <= cmd_count;
            end else if (r_state == S_EXEC) begin
                if (abort)
                    r_remaining <= '0;
                else if (r_remaining != '0)
                    r_remaining <= r_remaining - CNT_W'(1);
            end
        end
    end

    assign j         = w_j;
    assign k         = w_k;
    assign q         = r_q;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_EXEC);
    assign done      = (r_state == S_DONE);

endmodule
